// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit multiplexed common-anode 7-segment scanner
// Strobe-driven digit scan with anti-ghost gap, per-frame input snapshot and leading-zero blanking.
module seg7_scan #(
  parameter int BLANK_CLKS = 64,
  parameter bit SCAN_EDGE  = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        segclk,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        lzs,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_o,
  output logic        frame
);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  // With no gap configured the counter compare still hits at 0, so reset exits BLANK at once.
  localparam logic [15:0] LAST_CNT = (BLANK_CLKS == 0) ? 16'd0 : 16'(BLANK_CLKS - 1);

  state_t      state_q, state_d;
  logic        segclk_hist_q, segclk_hist_d;
  logic        load_pend_q, load_pend_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] val_sh_q, val_sh_d;
  logic [3:0]  dp_sh_q, dp_sh_d;
  logic [3:0]  blank_sh_q, blank_sh_d;
  logic        lzs_sh_q, lzs_sh_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_o_q, dp_o_d;
  logic        frame_q, frame_d;

  logic        tick;
  logic [3:0]  nib;
  logic        lead_zero;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick          = (segclk != segclk_hist_q) && (segclk == SCAN_EDGE);
    state_d       = state_q;
    segclk_hist_d = segclk;
    load_pend_d   = 1'b0;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    val_sh_d      = val_sh_q;
    dp_sh_d       = dp_sh_q;
    blank_sh_d    = blank_sh_q;
    lzs_sh_d      = lzs_sh_q;
    frame_d       = tick && (idx_q == 2'd3);

    if (load_pend_q || (tick && (idx_q == 2'd3))) begin
      val_sh_d   = value;
      dp_sh_d    = dp;
      blank_sh_d = blank;
      lzs_sh_d   = lzs;
    end

    // A tick always wins over the gap counter, even in the middle of a gap.
    if (tick) begin
      idx_d   = idx_q + 2'd1;
      cnt_d   = 16'd0;
      state_d = (BLANK_CLKS == 0) ? ST_SHOW : ST_BLANK;
    end else if (state_q == ST_BLANK) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q == LAST_CNT) begin
        state_d = ST_SHOW;
      end
    end
  end

  always_comb begin
    nib       = val_sh_q[{idx_q, 2'b00} +: 4];
    lead_zero = (idx_q != 2'd0) && ((val_sh_q >> {idx_q, 2'b00}) == 16'd0);
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;
    dp_o_d    = 1'b1;

    if ((state_q == ST_SHOW) && !blank_sh_q[idx_q]) begin
      if (lzs_sh_q && lead_zero) begin
        // Suppressed digit only drives its anode when its decimal point must be shown.
        if (dp_sh_q[idx_q]) begin
          an_d   = ~(4'b0001 << idx_q);
          dp_o_d = 1'b0;
        end
      end else begin
        an_d   = ~(4'b0001 << idx_q);
        seg_d  = hex_to_seg(nib);
        dp_o_d = ~dp_sh_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q       <= ST_BLANK;
      segclk_hist_q <= SCAN_EDGE;
      load_pend_q   <= 1'b1;
      idx_q         <= 2'd0;
      cnt_q         <= 16'd0;
      val_sh_q      <= 16'd0;
      dp_sh_q       <= 4'd0;
      blank_sh_q    <= 4'd0;
      lzs_sh_q      <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_o_q        <= 1'b1;
      frame_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      segclk_hist_q <= segclk_hist_d;
      load_pend_q   <= load_pend_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      val_sh_q      <= val_sh_d;
      dp_sh_q       <= dp_sh_d;
      blank_sh_q    <= blank_sh_d;
      lzs_sh_q      <= lzs_sh_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_o_q        <= dp_o_d;
      frame_q       <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp_o  = dp_o_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - scoreboard bench for seg7_scan
module tb_seg7_scan;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        segclk;
  logic        segclk0;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lzs;
  logic [3:0]  an, an0;
  logic [6:0]  seg, seg0;
  logic        dp_o, dp_o0;
  logic        frame, frame0;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   frames = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S8 = 7'b0000000, SA = 7'b0001000, SC = 7'b1000110,
                         SF = 7'b0001110, SOFF = 7'b1111111;

  seg7_scan #(.BLANK_CLKS(4), .SCAN_EDGE(1'b1)) dut (
    .clk(clk), .clr(clr), .segclk(segclk), .value(value), .dp(dp), .blank(blank),
    .lzs(lzs), .an(an), .seg(seg), .dp_o(dp_o), .frame(frame)
  );

  seg7_scan #(.BLANK_CLKS(0), .SCAN_EDGE(1'b1)) dut0 (
    .clk(clk), .clr(clr), .segclk(segclk0), .value(value), .dp(dp), .blank(blank),
    .lzs(lzs), .an(an0), .seg(seg0), .dp_o(dp_o0), .frame(frame0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int g);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d; e.gap = g;
    sb.push_back(e);
  endtask

  // One full segclk period ending in a rising edge; the digit it selects is pushed first.
  task automatic tick_to(input logic vis, input logic [3:0] a, input logic [6:0] s,
                         input logic d, input int g);
    if (vis) push(a, s, d, g);
    segclk = 1'b0;
    step(20);
    segclk = 1'b1;
    step(20);
  endtask

  initial begin : monitor
    logic [3:0] prev_an;
    int gap;
    exp_t e;
    prev_an = 4'hF;
    gap = 0;
    forever begin
      @(negedge clk);
      if (frame) frames++;
      if (an == 4'hF) begin
        gap++;
      end else if (prev_an == 4'hF) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_digit: got an=%b seg=%b want none", an, seg);
        end else begin
          e = sb.pop_front();
          chk("digit_an", 32'(an), 32'(e.an));
          chk("digit_seg", 32'(seg), 32'(e.seg));
          chk("digit_dp", 32'(dp_o), 32'(e.dp));
          if (e.gap >= 0) chk("digit_gap", 32'(gap), 32'(e.gap));
        end
        gap = 0;
      end
      prev_an = an;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    clr = 1'b0; segclk = 1'b1; segclk0 = 1'b1;
    value = 16'h1234; dp = 4'b0000; blank = 4'b0000; lzs = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'(SOFF));
    chk("rst_dp", 32'(dp_o), 32'h1);
    chk("rst_frame", 32'(frame), 32'h0);

    // Scan order and gap on 1234
    push(4'b1110, S4, 1'b1, -1);
    clr = 1'b1;
    step(10);
    tick_to(1'b1, 4'b1101, S3, 1'b1, 4);
    tick_to(1'b1, 4'b1011, S2, 1'b1, 4);
    tick_to(1'b1, 4'b0111, S1, 1'b1, 4);
    value = 16'h0050; lzs = 1'b1; dp = 4'b0100;

    // Leading-zero frame: digit 3 dark, digit 2 shows only its dp
    tick_to(1'b1, 4'b1110, S0, 1'b1, 4);
    tick_to(1'b1, 4'b1101, S5, 1'b1, 4);
    tick_to(1'b1, 4'b1011, SOFF, 1'b0, 4);
    tick_to(1'b0, 4'b0111, SOFF, 1'b1, 0);
    lzs = 1'b0;

    tick_to(1'b1, 4'b1110, S0, 1'b1, 44);
    tick_to(1'b1, 4'b1101, S5, 1'b1, 4);
    tick_to(1'b1, 4'b1011, S0, 1'b0, 4);
    tick_to(1'b1, 4'b0111, S0, 1'b1, 4);
    value = 16'hAAAA; dp = 4'b0000;

    // Snapshot: mid-frame change must not reach digits 2 and 3
    tick_to(1'b1, 4'b1110, SA, 1'b1, 4);
    tick_to(1'b1, 4'b1101, SA, 1'b1, 4);
    value = 16'hFFFF;
    tick_to(1'b1, 4'b1011, SA, 1'b1, 4);
    tick_to(1'b1, 4'b0111, SA, 1'b1, 4);
    tick_to(1'b1, 4'b1110, SF, 1'b1, 4);
    tick_to(1'b1, 4'b1101, SF, 1'b1, 4);
    tick_to(1'b1, 4'b1011, SF, 1'b1, 4);
    tick_to(1'b1, 4'b0111, SF, 1'b1, 4);
    value = 16'h8888; blank = 4'b1001;

    // Force blank on digits 3 and 0
    tick_to(1'b0, 4'b1110, SOFF, 1'b1, 0);
    tick_to(1'b1, 4'b1101, S8, 1'b1, 44);
    tick_to(1'b1, 4'b1011, S8, 1'b1, 4);
    tick_to(1'b0, 4'b0111, SOFF, 1'b1, 0);
    value = 16'h5A3C; blank = 4'b0000;
    tick_to(1'b1, 4'b1110, SC, 1'b1, 44);

    // Reset mid-SHOW with segclk high
    value = 16'h7E21;
    clr = 1'b0;
    step(1);
    @(negedge clk);
    chk("clr_an", 32'(an), 32'hF);
    chk("clr_seg", 32'(seg), 32'(SOFF));
    chk("clr_dp", 32'(dp_o), 32'h1);
    chk("clr_frame", 32'(frame), 32'h0);
    push(4'b1110, S1, 1'b1, -1);
    step(2);
    clr = 1'b1;
    step(4);
    @(negedge clk);
    chk("rel_gap_off", 32'(an), 32'hF);
    step(1);
    @(negedge clk);
    chk("rel_digit0", 32'(an), 32'hE);
    step(30);
    @(negedge clk);
    chk("rel_no_tick", 32'(an), 32'hE);
    tick_to(1'b1, 4'b1101, S2, 1'b1, 4);
    step(10);

    // Zero-gap instance: new anode one clk after the tick edge
    segclk0 = 1'b0;
    step(5);
    segclk0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b0_old_digit", 32'(an0), 32'hE);
    @(posedge clk);
    @(negedge clk);
    chk("b0_new_an", 32'(an0), 32'hD);
    chk("b0_new_seg", 32'(seg0), 32'(S2));

    step(5);
    chk("frame_count", 32'(frames), 32'd6);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
